// File: rtl/bolge_pkg.sv
// bolge_pkg: shared definitions for the bolge zone scheduler.
// Contents:
//   state_e     scheduler state enum, with the encoding driven on state_o
//   G_*         mode-select encodings of the g input
//   next_state  maps the global enable and the mode select to the next state
package bolge_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    ALL_ON = 2'd1,
    REQ    = 2'd2,
    SCAN   = 2'd3
  } state_e;

  localparam logic [1:0] G_ALL_LO = 2'b00;
  localparam logic [1:0] G_REQ    = 2'b01;
  localparam logic [1:0] G_SCAN   = 2'b10;
  localparam logic [1:0] G_ALL_HI = 2'b11;

  // A low global enable always wins over the mode select.
  // Both "all on" encodings map to the same state, so toggling between
  // them causes no state change.
  function automatic state_e next_state(input logic y, input logic [1:0] g);
    state_e ns;
    ns = BYPASS;
    if (!y) begin
      ns = BYPASS;
    end else begin
      case (g)
        G_REQ:   ns = REQ;
        G_SCAN:  ns = SCAN;
        G_ALL_LO,
        G_ALL_HI: ns = ALL_ON;
        default: ns = ALL_ON;
      endcase
    end
    return ns;
  endfunction

endpackage

// File: rtl/bolge_hold.sv
// bolge_hold: hold counter for one zone.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          high when the scheduler's next state is REQ; low clears the counter
//   req         this zone's request
//   b_o         zone drive contribution: req OR (counter != 0), using the
//               counter value before this cycle's update
// Behaviour:
//   A request loads the counter with HOLD. Otherwise a nonzero counter
//   counts down by one and stops at zero.
module bolge_hold #(
  parameter int HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req,
  output logic b_o
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next counter value: load on request, count down to zero, clear outside REQ.
  always_comb begin
    cnt_d = CNT_ZERO;
    if (!en) begin
      cnt_d = CNT_ZERO;
    end else if (req) begin
      cnt_d = CNT_HOLD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  assign b_o = req | (cnt_q != CNT_ZERO);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bolge_sched.sv
// bolge_sched: zone drive scheduler with BYPASS, ALL_ON, REQ and SCAN modes.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   y           global enable; 0 selects BYPASS, which drives every zone on
//   g           mode select: 00/11 ALL_ON, 01 REQ, 10 SCAN
//   r           per-zone requests, used in REQ mode only
//   b           registered per-zone drive
//   state_o     current state (BYPASS=0, ALL_ON=1, REQ=2, SCAN=3)
//   scan_idx    zone being driven in SCAN; 0 in every other state
// Timing:
//   All outputs are registered from the next-state values, so the response to
//   an input appears one cycle after it is sampled.
module bolge_sched
  import bolge_pkg::*;
#(
  parameter int N     = 4,
  parameter int HOLD  = 8,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 y,
  input  logic [1:0]           g,
  input  logic [N-1:0]         r,
  output logic [N-1:0]         b,
  output logic [1:0]           state_o,
  output logic [$clog2(N)-1:0] scan_idx
);

  localparam int IW = $clog2(N);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);
  localparam logic [DW-1:0] DWELL_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  B_ZERO     = {N{1'b0}};
  localparam logic [N-1:0]  B_ONES     = {N{1'b1}};
  localparam logic [N-1:0]  B_BIT0     = {{(N-1){1'b0}}, 1'b1};

  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;
  logic [N-1:0]  b_q;
  logic [N-1:0]  b_d;
  logic [N-1:0]  hold_b;
  logic          hold_en;

  // Next state from the enable and the mode select.
  always_comb begin
    state_d = next_state(y, g);
  end

  // The hold counters run only while the next state is REQ.
  // Any other next state clears them on the same edge.
  assign hold_en = (state_d == REQ);

  for (genvar gi = 0; gi < N; gi++) begin : g_hold
    bolge_hold #(.HOLD(HOLD)) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (hold_en),
      .req   (r[gi]),
      .b_o   (hold_b[gi])
    );
  end

  // Scan pointer and dwell count.
  // Entering SCAN starts at zone 0 with a fresh dwell count. dwell_q counts
  // the cycles already spent on the current zone, minus one.
  always_comb begin
    idx_d   = IDX_ZERO;
    dwell_d = DWELL_ZERO;
    if (state_d != SCAN) begin
      idx_d   = IDX_ZERO;
      dwell_d = DWELL_ZERO;
    end else if (state_q != SCAN) begin
      idx_d   = IDX_ZERO;
      dwell_d = DWELL_ZERO;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = DWELL_ZERO;
      if (idx_q == IDX_LAST) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      dwell_d = dwell_q + DWELL_ONE;
      idx_d   = idx_q;
    end
  end

  // Output mux, selected by the next state.
  always_comb begin
    b_d = B_ONES;
    case (state_d)
      BYPASS:  b_d = B_ONES;
      ALL_ON:  b_d = B_ONES;
      REQ:     b_d = hold_b;
      SCAN:    b_d = B_BIT0 << idx_d;
      default: b_d = B_ONES;
    endcase
  end

  // State, scan and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BYPASS;
      idx_q   <= IDX_ZERO;
      dwell_q <= DWELL_ZERO;
      b_q     <= B_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      b_q     <= b_d;
    end
  end

  assign b        = b_q;
  assign state_o  = state_q;
  assign scan_idx = idx_q;

endmodule
